// File: rtl/dt_ridge_extract.sv
// dt_ridge_extract
// Scans a completed 128x128 distance map in raster order and marks ridge
// pixels: nonzero interior pixels whose value is >= each of their four
// neighbours. The result is written as a packed 1-bit skeleton image, one
// 16-pixel word per write, with the leftmost pixel in the MSB. The block also
// reports the largest interior distance value and the number of ridge pixels.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   start      one-cycle pulse, accepted in IDLE or DONE
//   done       high from scan completion until the next accepted start/reset
//   res_rd     result RAM read enable
//   res_addr   result RAM address {row, col}
//   res_di     result RAM data, valid the cycle after res_rd
//   sk_wr      skeleton RAM write strobe
//   sk_addr    skeleton word address {row, col[6:4]}
//   sk_do      skeleton word, pixel col c at bit 15-c[3:0]
//   max_dist   maximum interior centre value
//   ridge_cnt  ridge pixel count
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for start after reset
//   S_CENTER | border pixel: accumulate a 0; interior: centre read on the bus
//   S_CWAIT  | centre value returns; latch it, skip neighbours if zero
//   S_NBR    | neighbour reads N, W, E, S, comparing each one a cycle later
//   S_EVAL   | last (S) compare, decide ridge, accumulate the bit
//   S_WRITE  | completed 16-pixel word on the skeleton bus, advance pixel
//   S_DONE   | scan complete, results held
module dt_ridge_extract #(
    parameter int IMG_W = 128,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          res_rd,
    output logic [13:0]   res_addr,
    input  logic [DW-1:0] res_di,
    output logic          sk_wr,
    output logic [9:0]    sk_addr,
    output logic [15:0]   sk_do,
    output logic [DW-1:0] max_dist,
    output logic [13:0]   ridge_cnt
);

    localparam logic [6:0] LAST = 7'(IMG_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CENTER,
        S_CWAIT,
        S_NBR,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    row_q, row_d;
    logic [6:0]    col_q, col_d;
    logic [1:0]    nbr_q, nbr_d;
    logic [DW-1:0] ctr_q, ctr_d;
    logic          ge_q, ge_d;
    logic [15:0]   acc_q, acc_d;
    logic [DW-1:0] max_q, max_d;
    logic [13:0]   cnt_q, cnt_d;
    logic          res_rd_q, res_rd_d;
    logic [13:0]   res_addr_q, res_addr_d;
    logic          sk_wr_q, sk_wr_d;
    logic [9:0]    sk_addr_q, sk_addr_d;
    logic [15:0]   sk_do_q, sk_do_d;
    logic          done_q, done_d;

    logic          bit_en;
    logic          bit_val;

    function automatic logic is_border(input logic [6:0] r, input logic [6:0] c);
        return (r == 7'd0) || (r == LAST) || (c == 7'd0) || (c == LAST);
    endfunction

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        nbr_d   = nbr_q;
        ctr_d   = ctr_q;
        ge_d    = ge_q;
        acc_d   = acc_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        bit_en  = 1'b0;
        bit_val = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CENTER;
                    row_d   = 7'd0;
                    col_d   = 7'd0;
                    max_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_CENTER: begin
                if (is_border(row_q, col_q)) begin
                    bit_en = 1'b1;
                end else begin
                    state_d = S_CWAIT;
                end
            end
            S_CWAIT: begin
                ctr_d = res_di;
                if (res_di > max_q) begin
                    max_d = res_di;
                end
                if (res_di == '0) begin
                    bit_en = 1'b1;
                end else begin
                    state_d = S_NBR;
                    nbr_d   = 2'd0;
                    ge_d    = 1'b1;
                end
            end
            S_NBR: begin
                // nbr_q=0 only issues N; later cycles compare the previous read
                if (nbr_q != 2'd0) begin
                    ge_d = ge_q & (ctr_q >= res_di);
                end
                nbr_d = nbr_q + 2'd1;
                if (nbr_q == 2'd3) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                bit_en  = 1'b1;
                bit_val = ge_q & (ctr_q >= res_di);
                if (bit_val) begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            S_WRITE: begin
                acc_d = '0;
                col_d = col_q + 7'd1;
                if (col_q == LAST) begin
                    row_d = row_q + 7'd1;
                end
                if ((col_q == LAST) && (row_q == LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CENTER;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Last pixel of a word waits in S_WRITE; the column advances there.
        if (bit_en) begin
            acc_d[4'hF - col_q[3:0]] = bit_val;
            if (col_q[3:0] == 4'hF) begin
                state_d = S_WRITE;
            end else begin
                col_d   = col_q + 7'd1;
                state_d = S_CENTER;
            end
        end
    end

    // Bus outputs are registered, so they are derived from the next state.
    always_comb begin
        res_rd_d   = 1'b0;
        res_addr_d = res_addr_q;
        sk_wr_d    = 1'b0;
        sk_addr_d  = sk_addr_q;
        sk_do_d    = sk_do_q;
        done_d     = (state_d == S_DONE);

        if ((state_d == S_CENTER) && !is_border(row_d, col_d)) begin
            res_rd_d   = 1'b1;
            res_addr_d = {row_d, col_d};
        end else if (state_d == S_NBR) begin
            res_rd_d = 1'b1;
            case (nbr_d)
                2'd0:    res_addr_d = {row_q - 7'd1, col_q};
                2'd1:    res_addr_d = {row_q, col_q - 7'd1};
                2'd2:    res_addr_d = {row_q, col_q + 7'd1};
                default: res_addr_d = {row_q + 7'd1, col_q};
            endcase
        end

        if ((state_d == S_WRITE) && (state_q != S_WRITE)) begin
            sk_wr_d   = 1'b1;
            sk_addr_d = {row_q, col_q[6:4]};
            sk_do_d   = acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            nbr_q      <= '0;
            ctr_q      <= '0;
            ge_q       <= 1'b0;
            acc_q      <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            sk_wr_q    <= 1'b0;
            sk_addr_q  <= '0;
            sk_do_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            nbr_q      <= nbr_d;
            ctr_q      <= ctr_d;
            ge_q       <= ge_d;
            acc_q      <= acc_d;
            max_q      <= max_d;
            cnt_q      <= cnt_d;
            res_rd_q   <= res_rd_d;
            res_addr_q <= res_addr_d;
            sk_wr_q    <= sk_wr_d;
            sk_addr_q  <= sk_addr_d;
            sk_do_q    <= sk_do_d;
            done_q     <= done_d;
        end
    end

    assign done      = done_q;
    assign res_rd    = res_rd_q;
    assign res_addr  = res_addr_q;
    assign sk_wr     = sk_wr_q;
    assign sk_addr   = sk_addr_q;
    assign sk_do     = sk_do_q;
    assign max_dist  = max_q;
    assign ridge_cnt = cnt_q;

endmodule

// File: tb/tb_dt_ridge_extract.sv
// Testbench for dt_ridge_extract: result RAM model with one-cycle read
// latency, a scoreboard of expected skeleton writes, and a monitor that pops
// and compares every sk_wr.
module tb_dt_ridge_extract;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di = 8'd0;
    logic        sk_wr;
    logic [9:0]  sk_addr;
    logic [15:0] sk_do;
    logic [7:0]  max_dist;
    logic [13:0] ridge_cnt;

    int checks = 0;
    int errors = 0;

    localparam int SCAN_LIMIT = 128 * 128 * 7 + 1024 + 16;

    typedef struct packed {
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  res_mem [0:16383];
    logic [15:0] exp_w   [0:1023];

    always #5 clk = ~clk;

    dt_ridge_extract #(.IMG_W(128), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .res_rd    (res_rd),
        .res_addr  (res_addr),
        .res_di    (res_di),
        .sk_wr     (sk_wr),
        .sk_addr   (sk_addr),
        .sk_do     (sk_do),
        .max_dist  (max_dist),
        .ridge_cnt (ridge_cnt)
    );

    always @(posedge clk) begin
        if (res_rd) res_di <= res_mem[res_addr];
    end

    // Every nonzero interior pixel of the map sits away from the border, so
    // no read may ever touch row or col 0/127.
    always @(negedge clk) begin
        if (res_rd) begin
            checks++;
            if (res_addr[13:7] == 7'd0 || res_addr[13:7] == 7'd127 ||
                res_addr[6:0] == 7'd0 || res_addr[6:0] == 7'd127) begin
                errors++;
                $display("FAIL border_read: res_addr row=%0d col=%0d, required interior",
                         res_addr[13:7], res_addr[6:0]);
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (sk_wr) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: sk_addr=%0d sk_do=%h, no write expected",
                         sk_addr, sk_do);
            end else begin
                e = exp_q.pop_front();
                if (sk_addr !== e.a || sk_do !== e.d) begin
                    errors++;
                    $display("FAIL sk_word: got addr=%0d data=%h, expected addr=%0d data=%h",
                             sk_addr, sk_do, e.a, e.d);
                end
            end
        end
    end

    function automatic int idx(input int r, input int c);
        return r * 128 + c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_scan();
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back('{a: 10'(i), d: exp_w[i]});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < SCAN_LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: done=%0d after %0d cycles, required 1", name, done, n);
        end
    endtask

    task automatic check_results(input string name);
        chk({name, "_writes_left"}, exp_q.size(), 0);
        chk({name, "_done"}, done, 1);
        chk({name, "_max_dist"}, max_dist, 9);
        chk({name, "_ridge_cnt"}, ridge_cnt, 8);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_res_rd"}, res_rd, 0);
        chk({name, "_res_addr"}, res_addr, 0);
        chk({name, "_sk_wr"}, sk_wr, 0);
        chk({name, "_sk_addr"}, sk_addr, 0);
        chk({name, "_sk_do"}, sk_do, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_max_dist"}, max_dist, 0);
        chk({name, "_ridge_cnt"}, ridge_cnt, 0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 16384; i++) res_mem[i] = 8'd0;
        for (int i = 0; i < 1024; i++) exp_w[i] = 16'h0000;

        // Isolated single pixel: row 5, col 20 -> word 41, bit 11.
        res_mem[idx(5, 20)]   = 8'd1;
        exp_w[41]             = 16'h0800;
        // Word edges: col 15 is the LSB of word 24, col 112 the MSB of word 31.
        res_mem[idx(3, 15)]   = 8'd5;
        exp_w[24]             = 16'h0001;
        res_mem[idx(3, 112)]  = 8'd9;
        exp_w[31]             = 16'h8000;
        // 3x3 plateau rows 9-11, cols 25-27 with peak 2 at (10,26): the four
        // corners tie with their in-block neighbours and are ridges, the edge
        // midpoints see the peak and are not.
        for (int r = 9; r <= 11; r++)
            for (int c = 25; c <= 27; c++)
                res_mem[idx(r, c)] = 8'd1;
        res_mem[idx(10, 26)]  = 8'd2;
        exp_w[73]             = 16'h0050;
        exp_w[81]             = 16'h0020;
        exp_w[89]             = 16'h0050;
        // Border values are never read and must not reach max_dist.
        res_mem[idx(0, 5)]    = 8'd7;
        res_mem[idx(127, 127)] = 8'd200;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_init");
        reset = 1'b1;

        // Scan A, with a start pulse mid-scan that must be ignored.
        push_scan();
        pulse_start();
        repeat (5000) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("mid_start_done", done, 0);
        wait_done("scan_a");
        check_results("scan_a");

        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", done, 1);
        chk("done_hold_rd", res_rd, 0);

        // Restart from DONE; done clears the cycle after start is taken.
        push_scan();
        pulse_start();
        chk("restart_done_clr", done, 0);
        chk("restart_max_clr", max_dist, 0);
        chk("restart_cnt_clr", ridge_cnt, 0);

        // Abort with reset once row 60 is being scanned.
        n = 0;
        while (!(sk_wr && sk_addr == 10'd480) && n < SCAN_LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(sk_wr && sk_addr == 10'd480)) begin
            errors++;
            $display("FAIL row60_timeout: sk_addr=%0d, required write of word 480", sk_addr);
        end
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        check_reset_vals("rst_mid");
        repeat (20) @(posedge clk);
        #1;
        chk("rst_idle_done", done, 0);

        // Full scan after the abort must be complete and identical.
        push_scan();
        pulse_start();
        wait_done("scan_c");
        check_results("scan_c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
